atm_ledger_server: RTL and testbench

Bank-side responder for the ATM terminal. It accepts one request at a time over a valid/ready channel, resolves account numbers with a sequential table scan, and applies authentication, balance, withdraw, transfer and logout operations to an on-chip balance table. It returns a status code and balance over a second valid/ready channel. It sits behind the terminal FSM and is the single owner of balance state and PIN-lockout state.

---
 rtl/atm_pkg.sv | 48 ++++
 rtl/atm_acct_lookup.sv | 68 ++++++
 rtl/atm_ledger_server.sv | 229 ++++++++++++++++++++++
 tb/tb_atm_ledger_server.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// ============================================================================
// Module   : atm_pkg
// Brief    : Shared opcodes, status codes, widths and the constant account table.
// Revision : 1.0
// ============================================================================
`default_nettype none

package atm_pkg;

    localparam int ACC_W      = 12;
    localparam int PIN_W      = 4;
    localparam int AMT_W      = 11;
    localparam int BAL_W      = 16;
    localparam int TABLE_SIZE = 10;
    localparam int IDX_W      = 4;

    typedef enum logic [2:0] {
        OP_AUTH     = 3'd0,
        OP_BALANCE  = 3'd1,
        OP_WITHDRAW = 3'd2,
        OP_TRANSFER = 3'd3,
        OP_LOGOUT   = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        ST_OK           = 3'd0,
        ST_BAD_CRED     = 3'd1,
        ST_INSUFFICIENT = 3'd2,
        ST_NO_DEST      = 3'd3,
        ST_NOT_AUTH     = 3'd4,
        ST_LOCKED       = 3'd5,
        ST_OVERFLOW     = 3'd6,
        ST_BAD_OP       = 3'd7
    } status_e;

    localparam logic [ACC_W-1:0] ACCT_NUM [TABLE_SIZE] = '{
        12'd1,    12'd2175, 12'd2429, 12'd2125, 12'd2178,
        12'd2647, 12'd2816, 12'd2910, 12'd2299, 12'd2689
    };

    // Entry i is protected by PIN i.
    localparam logic [PIN_W-1:0] ACCT_PIN [TABLE_SIZE] = '{
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9
    };

endpackage

`default_nettype wire

// File: rtl/atm_acct_lookup.sv
// ============================================================================
// Module   : atm_acct_lookup
// Brief    : Sequential account-table scanner resolving two keys in parallel.
// Revision : 1.0
// ============================================================================
`default_nettype none

module atm_acct_lookup
    import atm_pkg::*;
#(
    parameter int NUM_ACCTS = TABLE_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ACC_W-1:0] src_key,
    input  logic [ACC_W-1:0] dst_key,
    output logic             done,
    output logic             src_hit,
    output logic [IDX_W-1:0] src_idx,
    output logic             dst_hit,
    output logic [IDX_W-1:0] dst_idx
);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_ACCTS - 1);

    logic             r_busy;
    logic [IDX_W-1:0] r_idx;

    // Keys are sampled from the cycle after start; hit flags keep the first match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_idx   <= '0;
            done    <= 1'b0;
            src_hit <= 1'b0;
            src_idx <= '0;
            dst_hit <= 1'b0;
            dst_idx <= '0;
        end else if (start) begin
            r_busy  <= 1'b1;
            r_idx   <= '0;
            done    <= 1'b0;
            src_hit <= 1'b0;
            dst_hit <= 1'b0;
        end else if (r_busy) begin
            if (!src_hit && (ACCT_NUM[r_idx] == src_key)) begin
                src_hit <= 1'b1;
                src_idx <= r_idx;
            end
            if (!dst_hit && (ACCT_NUM[r_idx] == dst_key)) begin
                dst_hit <= 1'b1;
                dst_idx <= r_idx;
            end
            if (r_idx == C_LAST_IDX) begin
                r_busy <= 1'b0;
                done   <= 1'b1;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/atm_ledger_server.sv
// ============================================================================
// Module   : atm_ledger_server
// Brief    : Bank-side ATM responder owning balances, PIN lockout and session.
// Revision : 1.0
// ============================================================================
`default_nettype none

module atm_ledger_server
    import atm_pkg::*;
#(
    parameter int               NUM_ACCTS     = 10,
    parameter logic [BAL_W-1:0] INIT_BALANCE  = 16'd500,
    parameter int               MAX_PIN_FAILS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [ACC_W-1:0] req_acc,
    input  logic [PIN_W-1:0] req_pin,
    input  logic [ACC_W-1:0] req_dest,
    input  logic [AMT_W-1:0] req_amount,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_status,
    output logic [BAL_W-1:0] rsp_balance,
    output logic             session_active
);

    localparam int               FAIL_W       = $clog2(MAX_PIN_FAILS + 1);
    localparam logic [FAIL_W-1:0] C_LOCK_AT   = FAIL_W'(MAX_PIN_FAILS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]        r_state, w_state_nxt;
    logic [2:0]        r_op;
    logic [ACC_W-1:0]  r_acc, r_dest;
    logic [PIN_W-1:0]  r_pin;
    logic [AMT_W-1:0]  r_amt;
    logic [BAL_W-1:0]  r_bal   [TABLE_SIZE];
    logic [FAIL_W-1:0] r_fails [TABLE_SIZE];
    logic [TABLE_SIZE-1:0] r_locked;
    logic              r_sess;
    logic [IDX_W-1:0]  r_sidx;

    logic              w_accept;
    logic              lk_done, lk_src_hit, lk_dst_hit;
    logic [IDX_W-1:0]  lk_src_idx, lk_dst_idx;

    status_e           w_status;
    logic [BAL_W-1:0]  w_rsp_bal;
    logic              w_sess_nxt;
    logic [IDX_W-1:0]  w_sidx_nxt;
    logic              w_src_we, w_dst_we, w_fail_inc, w_fail_clr, w_lock;
    logic [BAL_W-1:0]  w_src_new, w_dst_new;
    logic [BAL_W-1:0]  w_src_bal, w_dst_bal, w_amt_ext;
    logic [BAL_W:0]    w_dst_sum;

    assign w_accept       = req_valid && req_ready;
    assign session_active = r_sess;

    atm_acct_lookup #(
        .NUM_ACCTS (NUM_ACCTS)
    ) u_lookup (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_accept),
        .src_key (r_acc),
        .dst_key (r_dest),
        .done    (lk_done),
        .src_hit (lk_src_hit),
        .src_idx (lk_src_idx),
        .dst_hit (lk_dst_hit),
        .dst_idx (lk_dst_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_LOOKUP;
            S_LOOKUP: if (lk_done) w_state_nxt = S_EXEC;
            S_EXEC:   w_state_nxt = S_RESP;
            S_RESP:   if (rsp_valid && rsp_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_src_bal = r_bal[r_sidx];
    assign w_dst_bal = r_bal[lk_dst_idx];
    assign w_amt_ext = {{(BAL_W-AMT_W){1'b0}}, r_amt};
    assign w_dst_sum = {1'b0, w_dst_bal} + {1'b0, w_amt_ext};

    // Outcome of the captured request; only consumed while in EXEC.
    always_comb begin
        w_status   = ST_OK;
        w_rsp_bal  = '0;
        w_sess_nxt = r_sess;
        w_sidx_nxt = r_sidx;
        w_src_we   = 1'b0;
        w_src_new  = w_src_bal - w_amt_ext;
        w_dst_we   = 1'b0;
        w_dst_new  = w_dst_sum[BAL_W-1:0];
        w_fail_inc = 1'b0;
        w_fail_clr = 1'b0;
        w_lock     = 1'b0;
        case (r_op)
            OP_AUTH: begin
                w_sess_nxt = 1'b0;
                if (!lk_src_hit) begin
                    w_status = ST_BAD_CRED;
                end else if (r_locked[lk_src_idx]) begin
                    w_status = ST_LOCKED;
                end else if (r_pin != ACCT_PIN[lk_src_idx]) begin
                    w_status   = ST_BAD_CRED;
                    w_fail_inc = 1'b1;
                    w_lock     = (r_fails[lk_src_idx] == C_LOCK_AT);
                end else begin
                    w_fail_clr = 1'b1;
                    w_sess_nxt = 1'b1;
                    w_sidx_nxt = lk_src_idx;
                    w_rsp_bal  = r_bal[lk_src_idx];
                end
            end
            OP_BALANCE, OP_WITHDRAW, OP_TRANSFER: begin
                if (!r_sess) begin
                    w_status = ST_NOT_AUTH;
                end else begin
                    w_rsp_bal = w_src_bal;
                    if (r_op == OP_WITHDRAW) begin
                        if (w_amt_ext > w_src_bal) begin
                            w_status = ST_INSUFFICIENT;
                        end else begin
                            w_src_we  = 1'b1;
                            w_rsp_bal = w_src_new;
                        end
                    end else if (r_op == OP_TRANSFER) begin
                        if (!lk_dst_hit) begin
                            w_status = ST_NO_DEST;
                        end else if (w_amt_ext > w_src_bal) begin
                            w_status = ST_INSUFFICIENT;
                        end else if (w_dst_sum[BAL_W]) begin
                            w_status = ST_OVERFLOW;
                        end else if (lk_dst_idx != r_sidx) begin
                            w_src_we  = 1'b1;
                            w_dst_we  = 1'b1;
                            w_rsp_bal = w_src_new;
                        end
                    end
                end
            end
            OP_LOGOUT: w_sess_nxt = 1'b0;
            default:   w_status = ST_BAD_OP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_status  <= '0;
            rsp_balance <= '0;
            r_sess      <= 1'b0;
            r_sidx      <= '0;
            r_op        <= '0;
            r_acc       <= '0;
            r_dest      <= '0;
            r_pin       <= '0;
            r_amt       <= '0;
        end else begin
            req_ready <= (w_state_nxt == S_IDLE);
            if (w_accept) begin
                r_op   <= req_op;
                r_acc  <= req_acc;
                r_dest <= req_dest;
                r_pin  <= req_pin;
                r_amt  <= req_amount;
            end
            if (r_state == S_EXEC) begin
                rsp_valid   <= 1'b1;
                rsp_status  <= w_status;
                rsp_balance <= w_rsp_bal;
                r_sess      <= w_sess_nxt;
                r_sidx      <= w_sidx_nxt;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TABLE_SIZE; i++) begin
                r_bal[i]   <= INIT_BALANCE;
                r_fails[i] <= '0;
            end
            r_locked <= '0;
        end else if (r_state == S_EXEC) begin
            for (int i = 0; i < TABLE_SIZE; i++) begin
                if (w_src_we && (r_sidx == IDX_W'(i)))
                    r_bal[i] <= w_src_new;
                if (w_dst_we && (lk_dst_idx == IDX_W'(i)))
                    r_bal[i] <= w_dst_new;
                if (lk_src_idx == IDX_W'(i)) begin
                    if (w_fail_clr)
                        r_fails[i] <= '0;
                    else if (w_fail_inc)
                        r_fails[i] <= r_fails[i] + 1'b1;
                    if (w_lock)
                        r_locked[i] <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_atm_ledger_server.sv
// ============================================================================
// Module   : tb_atm_ledger_server
// Brief    : Directed plus randomized bench against a behavioural ledger model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_atm_ledger_server;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [11:0] req_acc = '0;
    logic [3:0]  req_pin = '0;
    logic [11:0] req_dest = '0;
    logic [10:0] req_amount = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [2:0]  rsp_status;
    logic [15:0] rsp_balance;
    logic        session_active;

    always #5 clk = ~clk;

    atm_ledger_server dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_acc        (req_acc),
        .req_pin        (req_pin),
        .req_dest       (req_dest),
        .req_amount     (req_amount),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_status     (rsp_status),
        .rsp_balance    (rsp_balance),
        .session_active (session_active)
    );

    int checks = 0;
    int errors = 0;

    int acct_tab [10] = '{1, 2175, 2429, 2125, 2178, 2647, 2816, 2910, 2299, 2689};
    int m_bal  [10];
    int m_fail [10];
    bit m_lock [10];
    bit m_sess;
    int m_sidx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int find_acct(input int num);
        for (int i = 0; i < 10; i++)
            if (acct_tab[i] == num) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 10; i++) begin
            m_bal[i]  = 500;
            m_fail[i] = 0;
            m_lock[i] = 1'b0;
        end
        m_sess = 1'b0;
        m_sidx = 0;
    endtask

    // Status codes: 0 OK 1 BAD_CRED 2 INSUFFICIENT 3 NO_DEST 4 NOT_AUTH 5 LOCKED 6 OVERFLOW 7 BAD_OP
    task automatic model_req(input int op, input int acc, input int pin, input int dest,
                             input int amt, output int st, output int bl);
        int s, d;
        st = 0;
        bl = 0;
        case (op)
            0: begin
                m_sess = 1'b0;
                s = find_acct(acc);
                if (s < 0) st = 1;
                else if (m_lock[s]) st = 5;
                else if (pin != s) begin
                    st = 1;
                    m_fail[s]++;
                    if (m_fail[s] >= 3) m_lock[s] = 1'b1;
                end else begin
                    m_fail[s] = 0;
                    m_sess = 1'b1;
                    m_sidx = s;
                    bl = m_bal[s];
                end
            end
            1, 2, 3: begin
                if (!m_sess) st = 4;
                else begin
                    s = m_sidx;
                    if (op == 2) begin
                        if (amt <= m_bal[s]) m_bal[s] -= amt;
                        else st = 2;
                    end else if (op == 3) begin
                        d = find_acct(dest);
                        if (d < 0) st = 3;
                        else if (amt > m_bal[s]) st = 2;
                        else if (m_bal[d] + amt > 65535) st = 6;
                        else if (d != s) begin
                            m_bal[s] -= amt;
                            m_bal[d] += amt;
                        end
                    end
                    bl = m_bal[s];
                end
            end
            4: m_sess = 1'b0;
            default: st = 7;
        endcase
    endtask

    task automatic run_req(input string tag, input int op, input int acc, input int pin,
                           input int dest, input int amt, input int hold);
        int est, ebl, lat, n;
        logic [2:0]  st0;
        logic [15:0] bl0;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_op     = 3'(op);
        req_acc    = 12'(acc);
        req_pin    = 4'(pin);
        req_dest   = 12'(dest);
        req_amount = 11'(amt);
        req_valid  = 1'b1;
        @(posedge clk);
        model_req(op, acc, pin, dest, amt, est, ebl);
        @(negedge clk);
        req_valid  = 1'b0;
        req_acc    = 12'($urandom);
        req_dest   = 12'($urandom);
        req_amount = 11'($urandom);
        req_pin    = 4'($urandom);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'd12);
        chk({tag, "_status"}, 32'(rsp_status), 32'(est));
        chk({tag, "_balance"}, 32'(rsp_balance), 32'(ebl));
        chk({tag, "_session"}, 32'(session_active), 32'(m_sess));
        st0 = rsp_status;
        bl0 = rsp_balance;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_status"}, 32'(rsp_status), 32'(st0));
            chk({tag, "_hold_balance"}, 32'(rsp_balance), 32'(bl0));
            chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, "_rsp_valid_fall"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_req_ready_rise"}, 32'(req_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_status"}, 32'(rsp_status), 32'd0);
        chk({tag, "_rsp_balance"}, 32'(rsp_balance), 32'd0);
        chk({tag, "_session"}, 32'(session_active), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int k, r, op, acc, pin, dest, amt, seen;
        model_reset();

        // Reset state and registered req_ready rise
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("req_ready_after_reset", 32'(req_ready), 32'd1);

        // Authentication and withdraw/balance sequence on 2429
        run_req("auth_2429", 0, 2429, 2, 0, 0, 0);
        run_req("wd_200", 2, 0, 0, 0, 200, 0);
        run_req("wd_301", 2, 0, 0, 0, 301, 0);
        run_req("bal_300", 1, 0, 0, 0, 0, 0);
        run_req("wd_0", 2, 0, 0, 0, 0, 0);

        // Transfers from a fresh ledger
        do_reset();
        run_req("auth_2429b", 0, 2429, 2, 0, 0, 0);
        run_req("xfer_100", 3, 0, 0, 2816, 100, 0);
        run_req("xfer_self", 3, 0, 0, 2429, 50, 0);
        run_req("xfer_too_big", 3, 0, 0, 2816, 401, 0);
        run_req("auth_2816", 0, 2816, 6, 0, 0, 0);
        run_req("xfer_nodest", 3, 0, 0, 999, 5, 0);

        // PIN lockout survives a correct PIN until reset
        run_req("bad_pin_1", 0, 2175, 7, 0, 0, 0);
        run_req("bad_pin_2", 0, 2175, 7, 0, 0, 0);
        run_req("bad_pin_3", 0, 2175, 7, 0, 0, 0);
        run_req("locked", 0, 2175, 1, 0, 0, 0);
        run_req("unknown_acct", 0, 1234, 1, 0, 0, 0);
        do_reset();
        run_req("unlocked", 0, 2175, 1, 0, 0, 0);

        // No-session behaviour, idempotent logout, illegal opcode with backpressure
        run_req("logout", 4, 0, 0, 0, 0, 0);
        run_req("bal_noauth", 1, 0, 0, 0, 0, 0);
        run_req("xfer_noauth", 3, 0, 0, 9999, 5, 0);
        run_req("logout_again", 4, 0, 0, 0, 0, 0);
        run_req("bad_op", 6, 0, 0, 0, 0, 5);

        // Reset during LOOKUP discards the in-flight withdraw
        run_req("auth_2910", 0, 2910, 7, 0, 0, 0);
        @(negedge clk);
        req_op = 3'd2; req_amount = 11'd100; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_abort");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        chk("mid_abort_no_rsp", 32'(seen), 32'd0);
        run_req("mid_abort_bal", 0, 2910, 7, 0, 0, 0);

        // Randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r < 3) op = 0;
            else if (r == 3) op = 1;
            else if (r < 6) op = 2;
            else if (r < 8) op = 3;
            else if (r == 8) op = 4;
            else op = 5 + $urandom_range(0, 2);
            k = $urandom_range(0, 9);
            acc = ($urandom_range(0, 9) < 8) ? acct_tab[k] : $urandom_range(0, 4095);
            pin = ($urandom_range(0, 9) < 7) ? k : $urandom_range(0, 15);
            dest = ($urandom_range(0, 9) < 8) ? acct_tab[$urandom_range(0, 9)]
                                              : $urandom_range(0, 4095);
            amt = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 400) : $urandom_range(0, 2047);
            run_req("rand", op, acc, pin, dest, amt, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
